// File: rtl/urna_arbiter.sv
// urna_arbiter: round-robin vote arbiter with saturating tallies and a three-state session FSM.
// Define URNA_BRANCO_EN to add a separate blank-vote tally (code 11) on output total_branco.
module urna_arbiter #(
  parameter int N_BOOTH = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 finish,
  input  logic [N_BOOTH-1:0]   req,
  input  logic [2*N_BOOTH-1:0] vote,
  output logic [N_BOOTH-1:0]   ack,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     total_c1,
  output logic [CNT_W-1:0]     total_c2,
  output logic [CNT_W-1:0]     total_null,
`ifdef URNA_BRANCO_EN
  output logic [CNT_W-1:0]     total_branco,
`endif
  output logic                 overflow
);

  localparam int PTR_W = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OPEN   = 2'b01,
    CLOSED = 2'b10
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               clr;
  logic               arb_en;
  logic [PTR_W-1:0]   ptr_q;
  logic [N_BOOTH-1:0] eligible;
  logic [N_BOOTH-1:0] grant;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [1:0]         vote_sel;
  int                 idx;

  function automatic logic at_max(input logic [CNT_W-1:0] v);
    return v == CNT_MAX;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return at_max(v) ? v : v + CNT_W'(1);
  endfunction

  // Session FSM: finish wins in OPEN because start is ignored there
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, CLOSED: begin
        if (start) begin
          state_d = OPEN;
          clr     = 1'b1;
        end
      end
      OPEN: begin
        if (finish) state_d = CLOSED;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb_en = (state_q == OPEN) && !finish;
  assign state  = state_q;

  // Rotating priority search starting just after the last winner
  always_comb begin
    eligible = req & ~ack;
    grant    = '0;
    found    = 1'b0;
    win_idx  = '0;
    vote_sel = 2'b00;
    idx      = 0;
    for (int k = 1; k <= N_BOOTH; k++) begin
      idx = (int'(ptr_q) + k) % N_BOOTH;
      if (arb_en && !found && eligible[idx]) begin
        found      = 1'b1;
        win_idx    = PTR_W'(idx);
        grant[idx] = 1'b1;
        vote_sel   = vote[2*idx +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_W'(N_BOOTH - 1);
      ack          <= '0;
      total_c1     <= '0;
      total_c2     <= '0;
      total_null   <= '0;
`ifdef URNA_BRANCO_EN
      total_branco <= '0;
`endif
      overflow     <= 1'b0;
    end else begin
      state_q <= state_d;
      ack     <= grant;
      if (clr) begin
        total_c1     <= '0;
        total_c2     <= '0;
        total_null   <= '0;
`ifdef URNA_BRANCO_EN
        total_branco <= '0;
`endif
        overflow     <= 1'b0;
      end else if (found) begin
        ptr_q <= win_idx;
        // A vote at saturation is still acked; it only raises the sticky flag
        case (vote_sel)
          2'b01: begin
            total_c1 <= sat_inc(total_c1);
            if (at_max(total_c1)) overflow <= 1'b1;
          end
          2'b10: begin
            total_c2 <= sat_inc(total_c2);
            if (at_max(total_c2)) overflow <= 1'b1;
          end
`ifdef URNA_BRANCO_EN
          2'b11: begin
            total_branco <= sat_inc(total_branco);
            if (at_max(total_branco)) overflow <= 1'b1;
          end
`endif
          default: begin
            total_null <= sat_inc(total_null);
            if (at_max(total_null)) overflow <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_urna_arbiter.sv
// Randomized and directed bench for urna_arbiter against an integer-level election model.
`timescale 1ns/1ps
module tb_urna_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           finish;
  logic [N-1:0]   req;
  logic [2*N-1:0] vote;
  logic [N-1:0]   ack;
  logic [1:0]     state;
  logic [W-1:0]   total_c1;
  logic [W-1:0]   total_c2;
  logic [W-1:0]   total_null;
`ifdef URNA_BRANCO_EN
  logic [W-1:0]   total_branco;
`endif
  logic           overflow;

  urna_arbiter #(.N_BOOTH(N), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .req(req), .vote(vote), .ack(ack), .state(state),
    .total_c1(total_c1), .total_c2(total_c2), .total_null(total_null),
`ifdef URNA_BRANCO_EN
    .total_branco(total_branco),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Election model: 0 idle, 1 open, 2 closed; ptr is the last booth served
  int           m_state, m_ptr, m_c1, m_c2, m_null, m_br;
  logic [N-1:0] m_ack;
  bit           m_ovf;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [N-1:0] active, prev_ack;
  int           pct;
  bit           rand_vote;
  logic [1:0]   fixed_code [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tally(input logic [1:0] code);
    case (code)
      2'b01: if (m_c1 == MAXV) m_ovf = 1; else m_c1++;
      2'b10: if (m_c2 == MAXV) m_ovf = 1; else m_c2++;
`ifdef URNA_BRANCO_EN
      2'b11: if (m_br == MAXV) m_ovf = 1; else m_br++;
`endif
      default: if (m_null == MAXV) m_ovf = 1; else m_null++;
    endcase
  endtask

  task automatic model_clear();
    m_c1 = 0; m_c2 = 0; m_null = 0; m_br = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int           win;
    logic [N-1:0] nack;
    win  = -1;
    nack = '0;
    if (m_state == 1 && !finish) begin
      for (int k = 1; k <= N; k++) begin
        int i = (m_ptr + k) % N;
        if (win < 0 && req[i] && !m_ack[i]) win = i;
      end
    end
    if (win >= 0) begin
      nack[win] = 1'b1;
      m_ptr     = win;
      tally(vote[2*win +: 2]);
    end
    if (start && m_state != 1) begin
      m_state = 1;
      model_clear();
    end else if (finish && m_state == 1) begin
      m_state = 2;
    end
    m_ack = nack;
  endtask

  task automatic compare_all();
    chk("ack", 32'(ack), 32'(m_ack));
    chk("state", 32'(state), m_state);
    chk("total_c1", 32'(total_c1), m_c1);
    chk("total_c2", 32'(total_c2), m_c2);
    chk("total_null", 32'(total_null), m_null);
`ifdef URNA_BRANCO_EN
    chk("total_branco", 32'(total_branco), m_br);
`endif
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: predict, clock, compare, then let booths react as real booths would
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    start  = 1'b0;
    finish = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && prev_ack[i]) req[i] = 1'b0;
      if (!req[i] && active[i] && $urandom_range(99) < pct) begin
        req[i] = 1'b1;
        vote[2*i +: 2] = rand_vote ? 2'($urandom_range(3)) : fixed_code[i];
      end
    end
    prev_ack = ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_c1", 32'(total_c1), 0);
    chk("rst_c2", 32'(total_c2), 0);
    chk("rst_null", 32'(total_null), 0);
`ifdef URNA_BRANCO_EN
    chk("rst_branco", 32'(total_branco), 0);
`endif
    chk("rst_overflow", 32'(overflow), 0);
    m_state  = 0;
    m_ack    = '0;
    m_ptr    = N - 1;
    model_clear();
    prev_ack = '0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int nacks;
    rst_n = 1'b1; start = 1'b0; finish = 1'b0; req = '0; vote = '0;
    active = '0; pct = 0; rand_vote = 0; prev_ack = '0;
    for (int i = 0; i < N; i++) fixed_code[i] = 2'b00;
    #1;
    do_reset();
    req[1] = 1'b1; vote[3:2] = 2'b01;
    step();
    chk("idle_no_ack", 32'(ack), 0);
    finish = 1'b1;
    step();
    chk("idle_finish_ignored", 32'(state), 0);
    req = '0;

    // Single vote from booth 0
    do_reset();
    start = 1'b1;
    step();
    chk("t1_state", 32'(state), 1);
    req[0] = 1'b1; vote[1:0] = 2'b01;
    step();
    chk("t1_ack", 32'(ack), 1);
    chk("t1_c1", 32'(total_c1), 1);
    step(); step();

    // All four booths at once, served 0,1,2,3 on consecutive cycles
    do_reset();
    start = 1'b1;
    step();
    req = 4'hF; vote = {2'b00, 2'b10, 2'b10, 2'b10};
    for (int k = 0; k < N; k++) begin
      step();
      chk("t2_order", 32'(ack), 1 << k);
    end
    step();
    chk("t2_c2", 32'(total_c2), 3);
    chk("t2_null", 32'(total_null), 1);

    // finish beats a same-cycle request; nothing granted while closed
    finish = 1'b1; req[2] = 1'b1; vote[5:4] = 2'b10;
    step();
    chk("t3_ack", 32'(ack), 0);
    chk("t3_state", 32'(state), 2);
    for (int k = 0; k < 3; k++) step();
    chk("t3_closed_ack", 32'(ack), 0);
    chk("t3_frozen_c2", 32'(total_c2), 3);

    // Reopen: totals cleared, pending booth 2 served next edge
    start = 1'b1;
    step();
    chk("t4_state", 32'(state), 1);
    chk("t4_c2", 32'(total_c2), 0);
    chk("t4_start_no_ack", 32'(ack), 0);
    step();
    chk("t4_ack", 32'(ack), 4);
    step(); step();

    // Code 11 from booth 0
    req[0] = 1'b1; vote[1:0] = 2'b11;
    step();
    chk("t5_ack", 32'(ack), 1);
`ifdef URNA_BRANCO_EN
    chk("t5_branco", 32'(total_branco), 1);
    chk("t5_null", 32'(total_null), 0);
`else
    chk("t5_null", 32'(total_null), 1);
`endif
    step(); step();

    // Saturation: 256 C1 votes from booth 1
    finish = 1'b1;
    step();
    start = 1'b1;
    step();
    active = 4'b0010; pct = 100; rand_vote = 0; fixed_code[1] = 2'b01;
    nacks = 0;
    for (int c = 0; c < 700 && nacks < 256; c++) begin
      step();
      if (ack[1]) begin
        nacks++;
        if (nacks == 255) chk("sat_pre_ovf", 32'(overflow), 0);
      end
    end
    chk("sat_acks", nacks, 256);
    chk("sat_c1", 32'(total_c1), MAXV);
    chk("sat_ovf", 32'(overflow), 1);
    active = '0;
    step(); step();

    // Random traffic with occasional session pulses
    active = 4'hF; pct = 50; rand_vote = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) < 3) start = 1'b1;
      if ($urandom_range(99) < 3) finish = 1'b1;
      step();
    end

    // Mid-session reset aborts; no votes until the next start
    if (m_state != 1) start = 1'b1;
    step();
    do_reset();
    for (int k = 0; k < 5; k++) step();
    chk("post_rst_ack", 32'(ack), 0);
    chk("post_rst_state", 32'(state), 0);
    start = 1'b1;
    for (int k = 0; k < 20; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
